// File: rtl/pokey_bus_pkg.sv
// Shared types for the POKEY bus master: request record, FSM state and register map.
package pokey_bus_pkg;

  typedef struct packed {
    logic       write;
    logic [3:0] addr;
    logic [7:0] data;
  } pokey_req_t;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } bus_state_e;

  localparam logic [3:0] AUDF1  = 4'h0;
  localparam logic [3:0] AUDC1  = 4'h1;
  localparam logic [3:0] AUDF2  = 4'h2;
  localparam logic [3:0] AUDC2  = 4'h3;
  localparam logic [3:0] AUDF3  = 4'h4;
  localparam logic [3:0] AUDC3  = 4'h5;
  localparam logic [3:0] AUDF4  = 4'h6;
  localparam logic [3:0] AUDC4  = 4'h7;
  localparam logic [3:0] AUDCTL = 4'h8;  // write side of address 8
  localparam logic [3:0] ALLPOT = 4'h8;  // read side of address 8
  localparam logic [3:0] RANDOM = 4'hA;
  localparam logic [3:0] SKCTL  = 4'hF;

endpackage

// File: rtl/pokey_req_fifo.sv
// Request FIFO for the POKEY bus master; combinational head, async clear.
module pokey_req_fifo
  import pokey_bus_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       push_i,
  input  logic       pop_i,
  input  pokey_req_t wdata_i,
  output pokey_req_t rdata_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one wrap bit so full and empty are distinguishable.
  logic [AW:0] wr_q, wr_d;
  logic [AW:0] rd_q, rd_d;
  pokey_req_t  mem_q [DEPTH];
  logic        do_push, do_pop;

  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign empty_o = (wr_q == rd_q);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (do_push) wr_d = wr_q + 1'b1;
    if (do_pop)  rd_d = rd_q + 1'b1;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/pokey_bus_master.sv
// 6502-style bus initiator for POKEY: phi2 generation, request FIFO, one access per phi2 period.
// POKEY_BUS_READ_EN enables register reads; without it every request is a write.
module pokey_bus_master
  import pokey_bus_pkg::*;
#(
  parameter int PHI2_HALF  = 33,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [3:0] req_addr,
  input  logic [7:0] req_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       phi2,
  output logic       readHighWriteLow,
  output logic       cs0Bar,
  output logic [3:0] A,
  output logic [7:0] D_out,
  output logic       D_oe,
  input  logic [7:0] D_in,
  output logic       busy
);

  localparam logic [7:0] HALF_LAST = 8'(PHI2_HALF - 1);

  logic [7:0] cnt_q, cnt_d;
  logic       phi2_q, phi2_d;
  logic       wrap, fall_evt;

  bus_state_e state_q;
  logic       cs_n_q, rw_q, doe_q;
  logic [3:0] a_q;
  logic [7:0] dout_q;

  pokey_req_t req_in, head;
  logic       fifo_full, fifo_empty, push, pop;

  assign wrap     = (cnt_q == HALF_LAST);
  assign fall_evt = wrap && phi2_q;

  always_comb begin
    cnt_d  = wrap ? 8'd0 : cnt_q + 8'd1;
    phi2_d = wrap ? ~phi2_q : phi2_q;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt_q  <= '0;
      phi2_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      phi2_q <= phi2_d;
    end
  end

`ifdef POKEY_BUS_READ_EN
  assign req_in.write = req_write;
`else
  assign req_in.write = 1'b1;
`endif
  assign req_in.addr  = req_addr;
  assign req_in.data  = req_data;

  assign push      = req_valid && !fifo_full;
  assign pop       = fall_evt && !fifo_empty;
  assign req_ready = !fifo_full;

  pokey_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .clr     (clr),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (req_in),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Every bus transition happens on the phi2 falling edge, so outputs stay
  // stable across the whole low+high period that POKEY samples on the rise.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= IDLE;
      cs_n_q  <= 1'b1;
      rw_q    <= 1'b1;
      a_q     <= '0;
      dout_q  <= '0;
      doe_q   <= 1'b0;
    end else if (fall_evt) begin
      if (!fifo_empty) begin
        state_q <= ACTIVE;
        cs_n_q  <= 1'b0;
        rw_q    <= ~head.write;
        a_q     <= head.addr;
        doe_q   <= head.write;
        if (head.write) dout_q <= head.data;
      end else begin
        state_q <= IDLE;
        cs_n_q  <= 1'b1;
        rw_q    <= 1'b1;
        doe_q   <= 1'b0;
      end
    end
  end

`ifdef POKEY_BUS_READ_EN
  logic       rsp_valid_q;
  logic [7:0] rsp_data_q;
  logic       rd_done;

  // rw_q high while ACTIVE marks the access now closing as a read.
  assign rd_done = fall_evt && (state_q == ACTIVE) && rw_q;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      rsp_valid_q <= rd_done;
      if (rd_done) rsp_data_q <= D_in;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
`else
  logic unused_rd;
  assign unused_rd = ^{D_in, req_write};
  assign rsp_valid = 1'b0;
  assign rsp_data  = '0;
`endif

  assign phi2             = phi2_q;
  assign readHighWriteLow = rw_q;
  assign cs0Bar           = cs_n_q;
  assign A                = a_q;
  assign D_out            = dout_q;
  assign D_oe             = doe_q;
  assign busy             = !fifo_empty || (state_q == ACTIVE);

endmodule
